// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU.
// Operands are reduced to magnitudes, divided unsigned over 32 iterations,
// then the signs are reapplied. div_busy stalls the pipeline while working.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start,
    input  logic [1:0]  div_op,
    input  logic [31:0] div_src0,
    input  logic [31:0] div_src1,
    input  logic [4:0]  div_rd,
    input  logic        div_flush,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] div_res,
    output logic [4:0]  div_rd_out
);

    localparam int unsigned W      = 32;
    localparam int unsigned CW     = 6;
    localparam int unsigned RW     = 5;
    localparam int unsigned LAST_IT = W - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [W-1:0]   src0_q;     // original dividend, kept for the divide-by-zero remainder
    logic [W-1:0]   dsr_q;      // divisor: raw until PREP, magnitude afterwards
    logic [W-1:0]   quo_q;
    logic [W-1:0]   rem_q;
    logic [1:0]     op_q;
    logic [RW-1:0]  rd_q;
    logic [CW-1:0]  cnt_q;
    logic           qsign_q;
    logic           rsign_q;

    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_abs;
    logic [W-1:0]   b_abs;
    logic [W:0]     shift_rem;
    logic [W:0]     trial;
    logic [W-1:0]   q_fix;
    logic [W-1:0]   r_fix;
    logic [W-1:0]   res_fix;

    // Magnitude conversion for signed ops; unsigned ops pass straight through.
    assign a_neg = ~op_q[1] & src0_q[W-1];
    assign b_neg = ~op_q[1] & dsr_q[W-1];
    assign a_abs = a_neg ? W'(-src0_q) : src0_q;
    assign b_abs = b_neg ? W'(-dsr_q)  : dsr_q;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    assign shift_rem = {rem_q, quo_q[W-1]};
    assign trial     = shift_rem - {1'b0, dsr_q};

    // Sign fix-up, with the divide-by-zero result overriding everything.
    always_comb begin
        q_fix = qsign_q ? W'(-quo_q) : quo_q;
        r_fix = rsign_q ? W'(-rem_q) : rem_q;
        if (dsr_q == '0) begin
            q_fix = '1;
            r_fix = src0_q;
        end
        res_fix = op_q[0] ? r_fix : q_fix;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        if (div_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (div_start) state_d = S_PREP;
                S_PREP: state_d = S_CALC;
                S_CALC: if (cnt_q == CW'(LAST_IT)) state_d = S_FIX;
                S_FIX:  state_d = S_DONE;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign div_busy = (state_q != S_IDLE);
    assign div_done = (state_q == S_DONE);

    // Datapath: operand capture, iteration registers and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src0_q     <= '0;
            dsr_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            qsign_q    <= 1'b0;
            rsign_q    <= 1'b0;
            div_res    <= '0;
            div_rd_out <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (div_start && !div_flush) begin
                        src0_q <= div_src0;
                        dsr_q  <= div_src1;
                        op_q   <= div_op;
                        rd_q   <= div_rd;
                    end
                end
                S_PREP: begin
                    quo_q   <= a_abs;
                    dsr_q   <= b_abs;
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    qsign_q <= a_neg ^ b_neg;
                    rsign_q <= a_neg;
                end
                S_CALC: begin
                    if (!trial[W]) begin
                        rem_q <= trial[W-1:0];
                        quo_q <= {quo_q[W-2:0], 1'b1};
                    end else begin
                        rem_q <= shift_rem[W-1:0];
                        quo_q <= {quo_q[W-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + CW'(1);
                end
                S_FIX: begin
                    if (!div_flush) begin
                        div_res    <= res_fix;
                        div_rd_out <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the LoongArch core's execute stage, downstream of the register file. Consumes the rj and rk read-port values and returns a quotient or remainder, plus the destination register index, to the write-back path. It implements DIV.W, MOD.W, DIV.WU and MOD.WU with a radix-2 restoring iteration. While it works, it holds the pipeline stalled through `div_busy`.

## Interface
- No parameters. Data width is fixed at 32 and the iteration count at 32.
- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `div_start`  in  1  request strobe. Sampled only in IDLE.
- `div_op`  in  2  operation: 00 DIV.W, 01 MOD.W, 10 DIV.WU, 11 MOD.WU.
- `div_src0`  in  32  dividend (rj value).
- `div_src1`  in  32  divisor (rk value).
- `div_rd`  in  5  destination register index, captured with the request.
- `div_flush`  in  1  abort the current operation (pipeline flush).
- `div_busy`  out  1  high from the cycle after acceptance through the DONE cycle.
- `div_done`  out  1  one-cycle pulse: result valid. Used directly as the write-back write enable.
- `div_res`  out  32  result, registered. Holds its value until the next `div_done`.
- `div_rd_out`  out  5  captured destination index, registered. Updates with `div_res`.

## Operation
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE: if `div_start` is high and `div_flush` is low, latch the operands, `div_op` and `div_rd`, then go to PREP.
- PREP: for signed ops, take absolute values of both operands and record the quotient sign (s0 XOR s1) and the remainder sign (s0). For unsigned ops, pass the operands through. Clear the partial remainder, load the 6-bit iteration counter with 0, go to CALC.
- CALC: one iteration per cycle.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from the 33-bit partial remainder.
  - If the result is non-negative, keep it and set the quotient LSB.
  - After 32 iterations (counter == 31), go to FIX.
- FIX: apply signs and load `div_res` and `div_rd_out`, then go to DONE.
  - Signed quotient: negate when the quotient sign is 1.
  - Signed remainder: negate when the dividend was negative. The remainder takes the sign of the dividend.
  - Select the quotient (DIV) or the remainder (MOD).
- DONE: `div_done` = 1 for this single cycle, then go to IDLE.
- Divide by zero (divisor == 0, any op): the FIX step is overridden. The quotient is 0xFFFFFFFF and the remainder is the original `div_src0`. Latency is unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF): DIV.W gives 0x80000000 and MOD.W gives 0. This falls out of the unsigned-magnitude datapath, and no trap is raised.
- `div_flush` high in any state: next state is IDLE, and no `div_done` follows for the aborted operation. `div_res` and `div_rd_out` keep their previous values. Flush takes priority over a same-cycle `div_start`.
- `div_start` while busy is ignored. No queueing.

## Timing
- Reset values: state IDLE, `div_busy` 0, `div_done` 0, `div_res` 0, `div_rd_out` 0. The counter and all internal registers are 0.
- Reset asserted mid-operation forces the reset values immediately (asynchronous). No `div_done` is produced afterwards.
- Request sampled in cycle 0 (the edge at the end of cycle 0):
  - cycle 1: PREP
  - cycles 2–33: CALC
  - cycle 34: FIX
  - cycle 35: DONE, with `div_done` = 1 and `div_res` valid
- `div_busy` is high in cycles 1–35. It is combinational from state (state != IDLE), with no extra latency.
- Earliest back-to-back request: `div_start` in cycle 36. Result in cycle 71.
- After a flush in cycle n, `div_busy` = 0 in cycle n+1. A new start is accepted in cycle n+1.
- The operand inputs need to be valid only in the acceptance cycle. Later changes have no effect.

## Test plan
- DIV.W 100 / 7, `div_rd` = 5.
  - `div_done` only in cycle 35, with `div_res` = 14 and `div_rd_out` = 5.
  - MOD.W with the same operands gives 2.
- DIV.W 0xFFFFFFF9 / 2 gives 0xFFFFFFFD. MOD.W 0xFFFFFFF9 / 2 gives 0xFFFFFFFF.
- DIV.WU 0xFFFFFFFF / 2 gives 0x7FFFFFFF. MOD.WU with the same operands gives 1.
- DIV.W 0x80000000 / 0xFFFFFFFF gives 0x80000000, and MOD.W gives 0. DIV.W 5 / 0 gives 0xFFFFFFFF, and MOD.W 5 / 0 gives 5. Each completes in cycle 35.
- Start DIV.W 100 / 7 and assert `div_flush` in cycle 10.
  - Required: `div_busy` = 0 in cycle 11, no `div_done`, `div_res` unchanged.
  - Then start DIV.WU 9 / 3 in cycle 11: `div_res` = 3 in cycle 46.
  - `div_start` pulses issued during busy cycles are ignored.
- Assert `rst` in cycle 20 of an operation.
  - Required: outputs go to 0 at once and no `div_done` follows.
  - After release, a fresh request completes exactly 35 cycles after acceptance.
